// File: rtl/opf_pkg.sv
// opf_pkg: widths, register count and the execute-side output bundle for operand_fetch.
package opf_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 2 ** REG_AW;
  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [REG_AW-1:0] dr;
    logic              wen;
  } opf_out_t;
endpackage

// File: rtl/opf_scoreboard.sv
// opf_scoreboard: per-register outstanding-write bits; a same-cycle set beats a clear.
module opf_scoreboard
  import opf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] rd1_idx,
  input  logic [REG_AW-1:0] rd2_idx,
  input  logic [REG_AW-1:0] dr_idx,
  output logic              busy1,
  output logic              busy2,
  output logic              busy_dr
);
  logic [NREGS-1:0] busy;
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end
  assign busy1   = busy[rd1_idx];
  assign busy2   = busy[rd2_idx];
  assign busy_dr = busy[dr_idx];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with RAW/WAW scoreboard and writeback bypass.
// Build option OPF_R0_ZERO_EN makes register 0 an architectural zero.
module operand_fetch
  import opf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_sr1,
  input  logic [REG_AW-1:0] in_sr2,
  input  logic [REG_AW-1:0] in_dr,
  input  logic              in_wen,
  output logic [REG_AW-1:0] rf_sr1,
  output logic [REG_AW-1:0] rf_sr2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_write,
  output logic [REG_AW-1:0] rf_dr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [REG_AW-1:0] out_dr,
  output logic              out_wen
);
  logic b1, b2, bd, m1, m2, md, z1, z2, sat1, sat2, hazard, issue, set_en;
  logic [DATA_W-1:0] op1, op2;
  opf_out_t out_q;
`ifdef OPF_R0_ZERO_EN
  assign z1       = in_sr1 == '0;
  assign z2       = in_sr2 == '0;
  assign set_en   = issue && in_wen && in_dr != '0;
  assign rf_write = wb_valid && wb_dr != '0;
`else
  assign z1       = 1'b0;
  assign z2       = 1'b0;
  assign set_en   = issue && in_wen;
  assign rf_write = wb_valid;
`endif
  opf_scoreboard u_sb (
    .clk(clk), .reset(reset),
    .set_en(set_en), .set_idx(in_dr),
    .clr_en(wb_valid), .clr_idx(wb_dr),
    .rd1_idx(in_sr1), .rd2_idx(in_sr2), .dr_idx(in_dr),
    .busy1(b1), .busy2(b2), .busy_dr(bd)
  );
  assign rf_sr1   = in_sr1;
  assign rf_sr2   = in_sr2;
  assign rf_dr    = wb_dr;
  assign rf_wdata = wb_data;
  // a writeback landing this cycle satisfies a busy source and supplies its value
  assign m1       = wb_valid && wb_dr == in_sr1;
  assign m2       = wb_valid && wb_dr == in_sr2;
  assign md       = wb_valid && wb_dr == in_dr;
  assign sat1     = z1 || !b1 || m1;
  assign sat2     = z2 || !b2 || m2;
  assign op1      = z1 ? '0 : m1 ? wb_data : rf_rd1;
  assign op2      = z2 ? '0 : m2 ? wb_data : rf_rd2;
  assign hazard   = !sat1 || !sat2 || (in_wen && bd && !md);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign issue    = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_q     <= '{op1: op1, op2: op2, dr: in_dr, wen: in_wen};
    end else if (out_ready) out_valid <= 1'b0;
  end
  assign out_op1 = out_q.op1;
  assign out_op2 = out_q.op2;
  assign out_dr  = out_q.dr;
  assign out_wen = out_q.wen;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios then random traffic against a behavioural model.
module tb_operand_fetch;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_wen = 1'b0;
  logic [4:0] in_sr1 = '0, in_sr2 = '0, in_dr = '0, rf_sr1, rf_sr2, rf_dr, wb_dr = '0, out_dr;
  logic [31:0] rf_rd1, rf_rd2, rf_wdata, wb_data = '0, out_op1, out_op2;
  logic rf_write, wb_valid = 1'b0, out_valid, out_ready = 1'b1, out_wen;
  logic [31:0] bank [32];
  bit mbusy [32];
  bit mvalid, mwen;
  logic [31:0] mop1, mop2;
  logic [4:0] mdr;
  int checks = 0, failures = 0;
  bit zero_mode;
  always #5 clk = ~clk;
  assign rf_rd1 = bank[rf_sr1];
  assign rf_rd2 = bank[rf_sr2];
  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_wen(in_wen),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_write(rf_write), .rf_dr(rf_dr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
    .out_op2(out_op2), .out_dr(out_dr), .out_wen(out_wen)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // newest architectural value of a register as seen by an instruction this cycle
  function automatic logic [31:0] src_val(logic [4:0] s);
    if (zero_mode && s == 0) return 32'h0;
    if (wb_valid && wb_dr == s) return wb_data;
    return bank[s];
  endfunction
  function automatic bit src_ok(logic [4:0] s);
    return (zero_mode && s == 0) || !mbusy[s] || (wb_valid && wb_dr == s);
  endfunction
  task automatic set_in(bit v, logic [4:0] s1, logic [4:0] s2, logic [4:0] d, bit w);
    in_valid = v; in_sr1 = s1; in_sr2 = s2; in_dr = d; in_wen = w;
  endtask
  task automatic set_wb(bit v, logic [4:0] d, logic [31:0] data);
    wb_valid = v; wb_dr = d; wb_data = data;
  endtask
  // one clock: check combinational outputs, advance model at the edge, check registers
  task automatic cycle();
    bit rdy, wr;
    #1;
    rdy = src_ok(in_sr1) && src_ok(in_sr2)
          && !(in_wen && mbusy[in_dr] && !(wb_valid && wb_dr == in_dr))
          && (!mvalid || out_ready);
    wr = wb_valid && !(zero_mode && wb_dr == 0);
    chk("in_ready", in_ready, rdy);
    chk("rf_write", rf_write, wr);
    chk("rf_sr1", rf_sr1, in_sr1);
    if (wb_valid) begin
      chk("rf_dr", rf_dr, wb_dr);
      chk("rf_wdata", rf_wdata, wb_data);
    end
    @(posedge clk);
    if (reset) begin
      mbusy = '{default: 0}; mvalid = 0; mop1 = 0; mop2 = 0; mdr = 0; mwen = 0;
    end else begin
      if (wb_valid) mbusy[wb_dr] = 0;
      if (in_valid && rdy) begin
        mop1 = src_val(in_sr1); mop2 = src_val(in_sr2); mdr = in_dr; mwen = in_wen;
        mvalid = 1;
        if (in_wen && !(zero_mode && in_dr == 0)) mbusy[in_dr] = 1;
      end else if (out_ready) mvalid = 0;
    end
    if (wr) bank[wb_dr] = wb_data;
    #1;
    chk("out_valid", out_valid, mvalid);
    chk("out_op1", out_op1, mop1);
    chk("out_op2", out_op2, mop2);
    chk("out_dr", out_dr, mdr);
    chk("out_wen", out_wen, mwen);
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] held;
    logic [4:0] pick;
    int nb;
`ifdef OPF_R0_ZERO_EN
    zero_mode = 1;
`else
    zero_mode = 0;
`endif
    for (int i = 0; i < 32; i++) bank[i] = $urandom;
    bank[0] = 32'h99; bank[3] = 32'h11; bank[4] = 32'h22;
    mbusy = '{default: 0}; mvalid = 0; mop1 = 0; mop2 = 0; mdr = 0; mwen = 0;
    @(negedge clk);
    cycle(); cycle();
    reset = 0;
    chk("reset_busy", dut.u_sb.busy, 32'h0);
    chk("reset_out_valid", out_valid, 0);
    set_in(1, 3, 4, 0, 0); cycle();
    chk("basic_op1", out_op1, 32'h11);
    chk("basic_op2", out_op2, 32'h22);
    set_in(1, 3, 4, 5, 1); cycle();
    set_in(1, 5, 4, 6, 0); cycle(); cycle();
    chk("raw_stall", in_ready, 0);
    set_wb(1, 5, 32'hABCD); cycle(); set_wb(0, 0, 0);
    chk("raw_bypass_op1", out_op1, 32'hABCD);
    chk("raw_busy5", dut.u_sb.busy[5], 0);
    set_in(1, 1, 2, 7, 1); cycle(); cycle();
    chk("waw_stall", in_ready, 0);
    set_wb(1, 7, 32'h77); cycle(); set_wb(0, 0, 0);
    chk("waw_busy7", dut.u_sb.busy[7], 1);
    chk("waw_issued", out_valid, 1);
    held = out_op1;
    out_ready = 0; set_in(1, 3, 4, 8, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_op1", out_op1, held);
      chk("bp_hold_dr", out_dr, 7);
    end
    out_ready = 1; cycle();
    chk("bp_load_dr", out_dr, 8);
    set_in(1, 0, 1, 9, 1); cycle();
    chk("pre_reset_busy9", dut.u_sb.busy[9], 1);
    set_in(0, 0, 0, 0, 0); reset = 1; cycle(); reset = 0;
    chk("mid_reset_busy", dut.u_sb.busy, 32'h0);
    chk("mid_reset_valid", out_valid, 0);
    set_in(1, 9, 9, 10, 0); cycle();
    chk("post_reset_issue", out_valid, 1);
`ifdef OPF_R0_ZERO_EN
    set_in(0, 0, 0, 0, 0); set_wb(1, 0, 32'h55); cycle();
    chk("r0_no_write", rf_write, 0);
    set_wb(0, 0, 0); set_in(1, 0, 0, 0, 1); cycle();
    chk("r0_op1", out_op1, 0);
    chk("r0_not_busy", dut.u_sb.busy[0], 0);
`endif
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      nb = 0; pick = 0;
      for (int r = 0; r < 32; r++) if (mbusy[r] && $urandom_range(0, nb) == 0) begin pick = 5'(r); nb++; end
      if (nb > 0 && $urandom_range(0, 2) != 0) set_wb(1, pick, $urandom);
      else if ($urandom_range(0, 7) == 0) set_wb(1, 5'($urandom), $urandom);
      else set_wb(0, 0, 0);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage that sits directly upstream of the 32 x 32 register bank's consumers. It accepts decoded instructions (two sources and one destination) and drives the bank's two read addresses. A 32-entry scoreboard blocks RAW and WAW hazards, and writeback data is bypassed onto the read path. Registered operands are handed to the execute stage over a valid/ready handshake. The block also owns the bank's write port, so writeback passes through it.

## Interface
- DATA_W, 32, operand/register width
- REG_AW, 5, register address width (2^REG_AW registers)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when high with in_valid
- in_sr1, in_sr2  in  REG_AW  source register indices
- in_dr  in  REG_AW  destination index
- in_wen  in  1  instruction will write in_dr
- rf_sr1, rf_sr2  out  REG_AW  bank read addresses (= in_sr1/in_sr2, combinational)
- rf_rd1, rf_rd2  in  DATA_W  bank read data (combinational from the bank)
- rf_write  out  1  bank write enable
- rf_dr  out  REG_AW  bank write address
- rf_wdata  out  DATA_W  bank write data
- wb_valid  in  1  writeback this cycle
- wb_dr  in  REG_AW  writeback destination
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_op1, out_op2  out  DATA_W  source operands
- out_dr  out  REG_AW  destination
- out_wen  out  1  destination write flag

## Operation
- Scoreboard busy[2^REG_AW]. A set bit means a write to that register is outstanding.
- Bypass: srcN is satisfied if !busy[srN], or if wb_valid && wb_dr==srN this cycle. The operand value is then wb_data on an address match with wb_valid, otherwise rf_rdN.
- hazard = either source unsatisfied, or (in_wen && busy[in_dr] && !(wb_valid && wb_dr==in_dr)).
- in_ready = !hazard && (!out_valid || out_ready).
- Issue (in_valid && in_ready): load out_* and set out_valid=1. If in_wen, set busy[in_dr].
- Output drain: out_ready && out_valid && no issue -> out_valid=0. The out_* data fields hold their values.
- Writeback: rf_write=wb_valid, rf_dr=wb_dr, rf_wdata=wb_data, all combinational. wb_valid also clears busy[wb_dr].
- Same cycle, same register: issue-set wins over wb-clear, because the new write is younger.
- A writeback to a non-busy register is still written; busy stays 0.
- At most one outstanding write per register, which is guaranteed by the WAW stall.
- Reset: busy=0, out_valid=0, out_op1=out_op2=0, out_dr=0, out_wen=0.
- Reset mid-operation discards the held instruction. Later writebacks still reach the bank.

## Timing
- Latency: 1 cycle from issue to out_valid.
- Full throughput (1/cycle) when there are no hazards and out_ready=1.
- in_ready depends combinationally on out_ready, busy, and the wb_* inputs.
- A stalled source issues in the same cycle its writeback arrives, using the bypassed value. It does not wait a cycle.
- out_* are stable while out_valid && !out_ready.

## Configuration
- OPF_R0_ZERO_EN defined:
  - register 0 is architectural zero;
  - sources equal to 0 read 0 and are never busy;
  - in_wen with in_dr==0 does not set busy;
  - rf_write is suppressed when wb_dr==0.
- Undefined: register 0 behaves like every other register.

## Structure
- Package opf_pkg: DATA_W and REG_AW defaults, NREGS = 2**REG_AW, and a typedef for the out_* bundle.
- Sub-module opf_scoreboard: busy vector, set/clear ports with set priority, and two read ports plus one dr port. Hazard and bypass logic stay in operand_fetch.

## Test plan
- Reset, then issue sr1=3, sr2=4 with the bank holding r3=0x11 and r4=0x22 -> next cycle out_valid=1, out_op1=0x11, out_op2=0x22.
- RAW stall and bypass:
  - issue A: dr=5, wen=1;
  - then B: sr1=5 -> in_ready=0 until the cycle of wb_valid with wb_dr=5, wb_data=0xABCD;
  - B issues that cycle and its out_op1=0xABCD;
  - busy[5]=0 afterwards.
- WAW: A dr=7 is outstanding, B dr=7 is presented -> B stalls. Writeback r7 -> B issues the same cycle and busy[7]=1 (set wins over clear).
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* held constant. out_ready=1 -> the next instruction is loaded on that edge.
- Reset with busy[9]=1 and out_valid=1 -> busy=0 and out_valid=0. A following instruction with sr1=9 issues immediately.
- With OPF_R0_ZERO_EN:
  - writeback r0=0x55 -> rf_write=0;
  - issue sr1=0 -> out_op1=0;
  - in_dr=0 with wen=1 -> busy[0] stays 0.
